// File: rtl/dmem_arbiter.sv
// Two-lane data-memory arbiter: captures lane A/B requests into hold registers
// and serialises them onto one memory port, oldest lane (A) first.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid_a,
  input  logic        req_valid_b,
  output logic        req_ready_a,
  output logic        req_ready_b,
  input  logic [31:0] req_addr_a,
  input  logic [31:0] req_addr_b,
  input  logic [31:0] req_wdata_a,
  input  logic [31:0] req_wdata_b,
  input  logic [3:0]  req_we_a,
  input  logic [3:0]  req_we_b,
  input  logic        req_re_a,
  input  logic        req_re_b,
  output logic        resp_valid_a,
  output logic        resp_valid_b,
  output logic [31:0] resp_rdata_a,
  output logic [31:0] resp_rdata_b,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  output logic        dmem_re,
  input  logic [31:0] dmem_rdata,
  output logic        busy
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic        ready;
  logic        pend       [2];
  logic        accept     [2];
  logic        done       [2];
  logic        in_flight  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  req_t        req_in     [2];
  req_t        hold       [2];
  req_t        cur;

  assign ready       = (state == IDLE) && !pend[0] && !pend[1] && !flush;
  assign req_ready_a = ready;
  assign req_ready_b = ready;
  assign busy        = (state != IDLE) || pend[0] || pend[1];

  assign accept[0]    = req_valid_a && ready;
  assign accept[1]    = req_valid_b && ready;
  assign in_flight[0] = (state == BUSY_A);
  assign in_flight[1] = (state == BUSY_B);
  assign done[0]      = in_flight[0] && (cnt == 2'd0);
  assign done[1]      = in_flight[1] && (cnt == 2'd0);
  assign req_in[0]    = '{addr: req_addr_a, wdata: req_wdata_a, we: req_we_a, re: req_re_a};
  assign req_in[1]    = '{addr: req_addr_b, wdata: req_wdata_b, we: req_we_b, re: req_re_b};

  // Per-lane hold register and response; flush only drops a lane not on the port.
  for (genvar i = 0; i < 2; i++) begin : g_lane
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pend[i]       <= 1'b0;
        hold[i]       <= '0;
        resp_valid[i] <= 1'b0;
        resp_rdata[i] <= '0;
      end else begin
        resp_valid[i] <= done[i];
        if (done[i])
          resp_rdata[i] <= (hold[i].we == 4'b0 && hold[i].re) ? dmem_rdata : 32'b0;
        if (accept[i]) begin
          pend[i] <= 1'b1;
          hold[i] <= req_in[i];
        end else if (done[i] || (flush && !in_flight[i])) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  assign resp_valid_a = resp_valid[0];
  assign resp_valid_b = resp_valid[1];
  assign resp_rdata_a = resp_rdata[0];
  assign resp_rdata_b = resp_rdata[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept[0]) begin
            state <= BUSY_A;
            cnt   <= LAT_M1;
          end else if (accept[1]) begin
            state <= BUSY_B;
            cnt   <= LAT_M1;
          end
        end
        BUSY_A: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else if (pend[1] && !flush) begin
            state <= BUSY_B;
            cnt   <= LAT_M1;
          end else state <= IDLE;
        end
        BUSY_B: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port is driven only from the lane being served; a store masks the read.
  always_comb begin
    cur = '0;
    case (state)
      BUSY_A:  cur = hold[0];
      BUSY_B:  cur = hold[1];
      default: cur = '0;
    endcase
  end

  assign dmem_addr  = cur.addr;
  assign dmem_wdata = cur.wdata;
  assign dmem_we    = cur.we;
  assign dmem_re    = cur.re && (cur.we == 4'b0);

endmodule
